// File: rtl/ram_tp_req_ctrl.sv
// ram_tp_req_ctrl: valid/ready front-end for a two-port byte-masked RAM with a read-response FIFO; optional RAM_TP_REQ_CTRL_RAW_BYPASS_EN merges same-cycle write bytes into the read
module ram_tp_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int RSP_DEPTH = 3,
  localparam int BWEN_WIDTH = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LVL_WIDTH = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [BWEN_WIDTH-1:0] w_strb,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [LVL_WIDTH-1:0]  rsp_level,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [BWEN_WIDTH-1:0] ram_bwen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int PTR_WIDTH = $clog2(RSP_DEPTH);
  localparam int CNT_WIDTH = LVL_WIDTH + 1;
  logic                  inflight;
  logic                  w_fire;
  logic                  r_fire;
  logic                  pop;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] push_data;
  function automatic logic [PTR_WIDTH-1:0] nxt(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_ready = ~reset;
  // outstanding = buffered + in flight, so a granted read always has a slot when its data lands
  assign ar_ready = ~reset & (({1'b0, rsp_level} + CNT_WIDTH'(inflight)) < CNT_WIDTH'(RSP_DEPTH));
  assign w_fire = w_valid & w_ready;
  assign r_fire = ar_valid & ar_ready;
  assign pop = r_valid & r_ready;
  assign ram_wen = w_fire;
  assign ram_ren = r_fire;
  assign ram_cen = w_fire | r_fire;
  assign ram_bwen = w_strb;
  assign ram_waddr = w_addr;
  assign ram_wdata = w_data;
  assign ram_raddr = ar_addr;
  assign r_valid = (rsp_level != '0);
  assign r_data = r_valid ? fifo[rd_ptr] : '0;
`ifdef RAM_TP_REQ_CTRL_RAW_BYPASS_EN
  logic                  raw_q;
  logic [BWEN_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mask;
  // capture the colliding write alongside the in-flight read so its bytes override stale RAM data
  always_ff @(posedge clock) begin
    if (reset) begin
      raw_q <= 1'b0;
      strb_q <= '0;
      data_q <= '0;
    end else begin
      raw_q <= w_fire & r_fire & (w_addr == ar_addr);
      strb_q <= w_strb;
      data_q <= w_data;
    end
  end
  for (genvar i = 0; i < BWEN_WIDTH; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{raw_q & strb_q[i]}};
  end
  assign push_data = (ram_rdata & ~mask) | (data_q & mask);
`else
  assign push_data = ram_rdata;
`endif
  // response storage: the word returned by the RAM lands one cycle after the read was granted
  always_ff @(posedge clock) begin
    if (!reset && inflight) fifo[wr_ptr] <= push_data;
  end
  // in-flight tracking, circular pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rsp_level <= '0;
    end else begin
      inflight <= r_fire;
      if (inflight) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      rsp_level <= rsp_level + LVL_WIDTH'(inflight) - LVL_WIDTH'(pop);
    end
  end
endmodule
